// File: rtl/des_cbc_decrypt_if.sv
// ---------------------------------------------------------------------------
// des_cbc_decrypt_if
// Handshake and data bundle for the DES-CBC decryptor.
//   key        [64:1]  DES key (bit 64 = DES bit 1), parity bits unused
//   iv         [64:1]  initial chaining value, loaded by iv_load
//   iv_load            load iv into the chain register (IDLE only)
//   ciphertext [64:1]  ciphertext block, sampled with key at accept
//   in_valid / in_ready    input handshake
//   plaintext  [64:1]  recovered plaintext block
//   out_valid / out_ready  output handshake
// master: block producer/consumer side.  slave: the decryptor.
// ---------------------------------------------------------------------------
interface des_cbc_decrypt_if;
    logic [64:1] key;
    logic [64:1] iv;
    logic        iv_load;
    logic [64:1] ciphertext;
    logic        in_valid;
    logic        in_ready;
    logic [64:1] plaintext;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output key, iv, iv_load, ciphertext, in_valid, out_ready,
        input  in_ready, plaintext, out_valid
    );

    modport slave (
        input  key, iv, iv_load, ciphertext, in_valid, out_ready,
        output in_ready, plaintext, out_valid
    );
endinterface

// File: rtl/des_cbc_decrypt.sv
// ---------------------------------------------------------------------------
// des_cbc_decrypt
// Iterative DES-CBC decryptor, one Feistel round per clock.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  des_cbc_decrypt_if.slave (key/iv/ciphertext in, plaintext out)
// A block accepted at edge N (IP applied, key through PC-1) runs rounds
// 1..16 on edges N+1..N+16; the last round also performs swap, FP and the
// chain XOR, so plaintext/out_valid are present for the consumer at edge
// N+17. The chain register moves to the block's ciphertext only when the
// plaintext is taken. Only one block is in flight at a time.
// Internally all vectors are descending [N-1:0]; DES bit k of an N-bit
// quantity lives at index N-k, which the permutation helpers account for.
// ---------------------------------------------------------------------------
module des_cbc_decrypt (
    input  logic               clk,
    input  logic               rst,
    des_cbc_decrypt_if.slave   bus
);

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // S-boxes, flattened row-major: entry index = row*16 + column.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] perm_ip(input logic [63:0] d);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = d[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] d);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = d[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] d);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = d[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] d);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = d[56-PC2_T[i]];
        return o;
    endfunction

    // DES round function f(R, K): expand, key mix, S-boxes, P.
    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  b;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            b = x[47-6*j -: 6];
            // row = outer bits {b1,b6}, column = inner bits b2..b5
            s[31-4*j -: 4] = 4'(SBOX[j][{b[5], b[0], b[4:1]}]);
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

    state_t      state_reg;
    logic [4:0]  round_reg;
    logic [31:0] l_reg;
    logic [31:0] r_reg;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [63:0] ct_reg;
    logic [63:0] chain_reg;
    logic [63:0] pt_reg;
    logic        out_valid_reg;

    logic [47:0] subkey;
    logic [31:0] f_out;
    logic [31:0] r_next;
    logic        rot_one;
    logic [63:0] pt_next;

    // C/D start at C0/D0, which equal C16/D16, so round 1 uses K16 directly.
    // After round r the halves rotate right by the left-shift amount of
    // schedule step 17-r, yielding C(16-r)/D(16-r) for the next round.
    // Steps 1, 2, 9 and 16 shift by one, i.e. rounds 16, 15, 8 and 1.
    always_comb begin
        subkey  = perm_pc2({c_reg, d_reg});
        f_out   = feistel(r_reg, subkey);
        r_next  = l_reg ^ f_out;
        rot_one = (round_reg == 5'd1) || (round_reg == 5'd8) ||
                  (round_reg == 5'd15) || (round_reg == 5'd16);
        // Final swap: preoutput is R16 || L16, with L16 = R15.
        pt_next = perm_fp({r_next, r_reg}) ^ chain_reg;
    end

    // Reset also gates in_ready so it reads 0 throughout reset.
    assign bus.in_ready  = (state_reg == IDLE) && !bus.iv_load && !rst;
    assign bus.plaintext = pt_reg;
    assign bus.out_valid = out_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            round_reg     <= 5'd0;
            l_reg         <= 32'd0;
            r_reg         <= 32'd0;
            c_reg         <= 28'd0;
            d_reg         <= 28'd0;
            ct_reg        <= 64'd0;
            chain_reg     <= 64'd0;
            pt_reg        <= 64'd0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.iv_load) begin
                        chain_reg <= bus.iv;
                    end else if (bus.in_valid) begin
                        ct_reg         <= bus.ciphertext;
                        {c_reg, d_reg} <= perm_pc1(bus.key);
                        {l_reg, r_reg} <= perm_ip(bus.ciphertext);
                        round_reg      <= 5'd1;
                        state_reg      <= ROUND;
                    end
                end
                ROUND: begin
                    l_reg <= r_reg;
                    r_reg <= r_next;
                    if (rot_one) begin
                        c_reg <= {c_reg[0], c_reg[27:1]};
                        d_reg <= {d_reg[0], d_reg[27:1]};
                    end else begin
                        c_reg <= {c_reg[1:0], c_reg[27:2]};
                        d_reg <= {d_reg[1:0], d_reg[27:2]};
                    end
                    // The counter stops at 16; it is reloaded on the next accept.
                    if (round_reg == 5'd16) begin
                        pt_reg        <= pt_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end else begin
                        round_reg <= round_reg + 5'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        chain_reg     <= ct_reg;
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
